mpt2042_mchnl_dataprc: RTL and testbench
========================================

Name: mpt2042_mchnl_dataprc

Overview:
Parametrised successor to the single-channel MPT2042 frame decoder. Reads the 10-bit symbol FIFO fed by the LVDS IDDR/8b10b front end and parses one TDC frame per laser shot. Captures the first rising and first falling edge timestamp for up to CHNL_NUM channels, and flags timeout, error-marker and aborted frames. Sits between the LVDS decode FIFO and the distance-calculation pipeline.

Parameters:
CHNL_NUM, 4, number of TDC channels decoded (1..4; channel ID field is 2 bits)
DATA_W, 16, timestamp width per edge (fixed 16 in record format; outputs sized by it)
DELAY_CLKNUM, 5, clocks after i_laser_sync before parsing starts
TIMEOUT_CLKNUM, 4000, max clocks in COLLECT before forced frame close
CNT_W, 16, width of the delay/timeout counter

Ports:
i_clk_100m  in  1  system clock
i_rst  in  1  synchronous active-high reset
i_cdctdc_ready  in  1  TDC configured; leaves IDLE when high
i_tdc_strdy  in  1  measurement-start strobe, async to frame; 2-FF synchronised internally
i_laser_sync  in  1  laser fire pulse, one clock
i_chnl_en  in  CHNL_NUM  per-channel enable mask
i_lvdsfifo_empty  in  1  symbol FIFO empty
o_lvdsfifo_ren  out  1  FIFO read enable; data valid on i_lvdsfifo_rdata one clock later
i_lvdsfifo_rdata  in  10  symbol; bit9=1 marks control symbol
o_data_valid  out  1  one-clock result strobe
o_rise_data  out  CHNL_NUM*DATA_W  packed rise timestamps, channel 0 in LSBs
o_fall_data  out  CHNL_NUM*DATA_W  packed fall timestamps
o_edge_vld  out  2*CHNL_NUM  [c]=rise captured, [CHNL_NUM+c]=fall captured
o_status  out  3  {meas_fail, err_marker, timeout}

Behaviour:
- Reset: all outputs 0, state IDLE, all capture registers all-ones, flags cleared.
- Read rule: ren=1 only when !empty and the state consumes data; internal ren_d1 qualifies rdata. Never assert ren on empty.
- Symbols: data (bit9=0) is one byte. Control: 10'h29C = record separator; 10'h3FF = error marker; any other control = frame end.
- Record: 3 data bytes MSB first -> rec[23:0]. Channel = rec[23:22], valid = rec[20], edge = rec[19] (1=rise), time = rec[15:0]. Byte counter resets on 29C, so a short record is discarded; a 4th data byte without a separator is ignored until the next 29C.
- Capture: record is accepted if channel < CHNL_NUM, i_chnl_en[channel]=1 and valid=1. Only the first rise/fall per channel is kept; later ones are ignored.
- States:
  IDLE -> READY when i_cdctdc_ready.
  READY: drain FIFO continuously (ren=!empty, data discarded); clear captures to all-ones; -> DELAY on i_laser_sync.
  DELAY: count DELAY_CLKNUM clocks, then -> COLLECT. No reads.
  COLLECT: read and parse. Frame end -> OUTPUT. 3FF sets err_marker and continues. Counter reaching TIMEOUT_CLKNUM sets timeout -> OUTPUT.
  OUTPUT: one clock; register packed data/flags and pulse o_data_valid -> READY.
- Abort: synchronised i_tdc_strdy rising edge in DELAY or COLLECT sets meas_fail and forces OUTPUT next clock with the captures made so far. In READY or IDLE it is ignored.
- If i_laser_sync arrives outside READY, it is ignored.
- Outputs hold until the next OUTPUT; o_data_valid is high exactly one clock per shot.
- Latency: frame-end symbol on rdata -> o_data_valid two clocks later.
- If i_cdctdc_ready drops, the current frame is finished and the block then returns to IDLE instead of READY.
- i_rst mid-frame returns to IDLE next clock with outputs zeroed; no o_data_valid.

Test Plan:
1. CHNL_NUM=4, all enabled; frame ch0 rise 0x1234, 29C, ch0 fall 0x1300, end 0x2BC -> o_data_valid once; rise[15:0]=0x1234, fall[15:0]=0x1300; o_edge_vld=8'h11; status=0.
2. Two ch2 rise records (0x0100, then 0x0200) -> rise[47:32]=0x0100; ch1/ch3 fields=0xFFFF, corresponding edge_vld bits 0.
3. Record on ch1 with i_chnl_en=4'b1101, plus a record with valid bit=0 -> both dropped; o_edge_vld=0.
4. Record interrupted after 2 bytes by 29C, then a full ch3 fall 0xABCD -> only ch3 fall captured = 0xABCD.
5. No frame end, FIFO empty for TIMEOUT_CLKNUM -> o_status=3'b001 exactly TIMEOUT_CLKNUM clocks after COLLECT entry. 3FF inside a frame -> status bit1=1 and data still reported.
6. i_tdc_strdy pulse mid-COLLECT -> status=3'b100, o_data_valid within 4 clocks. Separately, i_rst mid-frame -> no strobe, outputs 0, IDLE.

Source files
------------

// File: rtl/mpt2042_mchnl_dataprc.sv
// mpt2042_mchnl_dataprc
//   Multi-channel TDC frame decoder. Pulls 10-bit symbols from the LVDS
//   8b10b decode FIFO, parses one frame per laser shot and reports the
//   first rise/fall timestamp per channel together with frame status.
//
// Ports
//   i_clk_100m, i_rst           clock, synchronous active-high reset
//   i_cdctdc_ready              TDC configured; gates IDLE -> READY
//   i_tdc_strdy                 async measurement-start strobe (abort)
//   i_laser_sync                one-clock laser fire pulse
//   i_chnl_en[CHNL_NUM]         per-channel capture enable
//   i_lvdsfifo_empty/_ren/_rdata symbol FIFO, rdata valid one clock after ren
//   o_data_valid                one-clock result strobe per shot
//   o_rise_data/o_fall_data     packed timestamps, channel 0 in LSBs
//   o_edge_vld                  [c]=rise seen, [CHNL_NUM+c]=fall seen
//   o_status                    {meas_fail, err_marker, timeout}

// Per-channel first-edge capture. Holds all-ones until the first hit of
// each polarity; later hits of the same polarity are ignored.
module mpt2042_chnl_cap #(
  parameter int DATA_W = 16
) (
  input  logic              i_clk_100m,
  input  logic              i_rst,
  input  logic              clr,
  input  logic              hit,
  input  logic              is_rise,
  input  logic [DATA_W-1:0] tstamp,
  output logic [DATA_W-1:0] rise_ts,
  output logic [DATA_W-1:0] fall_ts,
  output logic              rise_vld,
  output logic              fall_vld
);
  always_ff @(posedge i_clk_100m) begin
    if (i_rst || clr) begin
      rise_ts  <= '1;
      fall_ts  <= '1;
      rise_vld <= 1'b0;
      fall_vld <= 1'b0;
    end else if (hit) begin
      if (is_rise && !rise_vld) begin
        rise_ts  <= tstamp;
        rise_vld <= 1'b1;
      end
      if (!is_rise && !fall_vld) begin
        fall_ts  <= tstamp;
        fall_vld <= 1'b1;
      end
    end
  end
endmodule

module mpt2042_mchnl_dataprc #(
  parameter int CHNL_NUM       = 4,
  parameter int DATA_W         = 16,
  parameter int DELAY_CLKNUM   = 5,
  parameter int TIMEOUT_CLKNUM = 4000,
  parameter int CNT_W          = 16
) (
  input  logic                       i_clk_100m,
  input  logic                       i_rst,
  input  logic                       i_cdctdc_ready,
  input  logic                       i_tdc_strdy,
  input  logic                       i_laser_sync,
  input  logic [CHNL_NUM-1:0]        i_chnl_en,
  input  logic                       i_lvdsfifo_empty,
  output logic                       o_lvdsfifo_ren,
  input  logic [9:0]                 i_lvdsfifo_rdata,
  output logic                       o_data_valid,
  output logic [CHNL_NUM*DATA_W-1:0] o_rise_data,
  output logic [CHNL_NUM*DATA_W-1:0] o_fall_data,
  output logic [2*CHNL_NUM-1:0]      o_edge_vld,
  output logic [2:0]                 o_status
);
  localparam logic [9:0] SYM_SEP = 10'h29C;
  localparam logic [9:0] SYM_ERR = 10'h3FF;

  typedef enum logic [2:0] {S_IDLE, S_READY, S_DELAY, S_COLLECT, S_OUTPUT} state_t;
  state_t state, nxt_state;

  logic [CNT_W-1:0] cnt;
  logic             ren_d1;
  logic [1:0]       byte_cnt;   // 3 = record complete, extra bytes ignored
  logic [15:0]      rec_hi;     // first two bytes of the current record
  logic [2:0]       strdy_sync; // [1:0] synchroniser, [2] edge history
  logic             err_f, tmo_f, fail_f;

  logic             sym_vld, is_ctrl, sym_sep, sym_err, sym_end;
  logic             strdy_rise, abort, tmo_hit, rec_done;
  logic [23:0]      rec;
  logic [CHNL_NUM-1:0]             hit;
  logic [CHNL_NUM-1:0][DATA_W-1:0] rise_ts, fall_ts;
  logic [CHNL_NUM-1:0]             rise_v, fall_v;

  assign sym_vld    = ren_d1 && (state == S_COLLECT);
  assign is_ctrl    = i_lvdsfifo_rdata[9];
  assign sym_sep    = sym_vld && (i_lvdsfifo_rdata == SYM_SEP);
  assign sym_err    = sym_vld && (i_lvdsfifo_rdata == SYM_ERR);
  assign sym_end    = sym_vld && is_ctrl && !sym_sep && !sym_err;
  assign strdy_rise = strdy_sync[1] && !strdy_sync[2];
  assign abort      = strdy_rise && (state == S_DELAY || state == S_COLLECT);
  assign tmo_hit    = (state == S_COLLECT) && (cnt == CNT_W'(TIMEOUT_CLKNUM - 1));
  assign rec_done   = sym_vld && !is_ctrl && (byte_cnt == 2'd2);
  assign rec        = {rec_hi, i_lvdsfifo_rdata[7:0]};

  logic unused_ok;
  assign unused_ok = ^{i_lvdsfifo_rdata[8], rec[21], rec[18:16]};

  always_comb begin
    nxt_state = state;
    unique case (state)
      S_IDLE:    if (i_cdctdc_ready) nxt_state = S_READY;
      S_READY:   if (!i_cdctdc_ready)  nxt_state = S_IDLE;
                 else if (i_laser_sync) nxt_state = S_DELAY;
      S_DELAY:   if (abort) nxt_state = S_OUTPUT;
                 else if (cnt == CNT_W'(DELAY_CLKNUM - 1)) nxt_state = S_COLLECT;
      S_COLLECT: if (abort || sym_end || tmo_hit) nxt_state = S_OUTPUT;
      S_OUTPUT:  nxt_state = i_cdctdc_ready ? S_READY : S_IDLE;
      default:   nxt_state = S_IDLE;
    endcase
  end

  // No read in the last cycle of READY/COLLECT: that symbol would land in a
  // state that does not parse it and be lost.
  assign o_lvdsfifo_ren = !i_lvdsfifo_empty && (nxt_state == state) &&
                          (state == S_READY || state == S_COLLECT);

  always_comb begin
    hit = '0;
    for (int c = 0; c < CHNL_NUM; c++)
      hit[c] = rec_done && rec[20] && i_chnl_en[c] && (rec[23:22] == 2'(c));
  end

  for (genvar c = 0; c < CHNL_NUM; c++) begin : g_ch
    mpt2042_chnl_cap #(.DATA_W(DATA_W)) u_cap (
      .i_clk_100m (i_clk_100m),
      .i_rst      (i_rst),
      .clr        (state == S_READY),
      .hit        (hit[c]),
      .is_rise    (rec[19]),
      .tstamp     (DATA_W'(rec[15:0])),
      .rise_ts    (rise_ts[c]),
      .fall_ts    (fall_ts[c]),
      .rise_vld   (rise_v[c]),
      .fall_vld   (fall_v[c])
    );
  end

  always_ff @(posedge i_clk_100m) begin
    if (i_rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      ren_d1       <= 1'b0;
      byte_cnt     <= 2'd0;
      rec_hi       <= '0;
      strdy_sync   <= '0;
      err_f        <= 1'b0;
      tmo_f        <= 1'b0;
      fail_f       <= 1'b0;
      o_data_valid <= 1'b0;
      o_rise_data  <= '0;
      o_fall_data  <= '0;
      o_edge_vld   <= '0;
      o_status     <= '0;
    end else begin
      state      <= nxt_state;
      ren_d1     <= o_lvdsfifo_ren;
      strdy_sync <= {strdy_sync[1:0], i_tdc_strdy};

      if (state != nxt_state) cnt <= '0;
      else if (state == S_DELAY || state == S_COLLECT) cnt <= cnt + 1'b1;

      if (state != S_COLLECT) byte_cnt <= 2'd0;
      else if (sym_sep) byte_cnt <= 2'd0;
      else if (sym_vld && !is_ctrl && byte_cnt != 2'd3) begin
        byte_cnt <= byte_cnt + 2'd1;
        rec_hi   <= {rec_hi[7:0], i_lvdsfifo_rdata[7:0]};
      end

      if (state == S_IDLE || state == S_READY) begin
        err_f  <= 1'b0;
        tmo_f  <= 1'b0;
        fail_f <= 1'b0;
      end else begin
        if (sym_err) err_f  <= 1'b1;
        if (abort)   fail_f <= 1'b1;
        if (tmo_hit && !sym_end && !abort) tmo_f <= 1'b1;
      end

      o_data_valid <= (state == S_OUTPUT);
      if (state == S_OUTPUT) begin
        o_rise_data <= rise_ts;
        o_fall_data <= fall_ts;
        o_edge_vld  <= {fall_v, rise_v};
        o_status    <= {fail_f, err_f, tmo_f};
      end
    end
  end
endmodule

// File: tb/tb_mpt2042_mchnl_dataprc.sv
// Directed bench for mpt2042_mchnl_dataprc: a queue-backed FIFO model feeds
// symbol frames, expected results are queued per shot and checked on the
// o_data_valid strobe.
module tb_mpt2042_mchnl_dataprc;
  localparam int CH = 4, DW = 16, DLY = 5, TMO = 40;

  logic              clk = 1'b0;
  logic              rst, cd_rdy, strdy, laser, empty, ren, dvalid;
  logic [CH-1:0]     en;
  logic [9:0]        rdata;
  logic [CH*DW-1:0]  rise, fall;
  logic [2*CH-1:0]   ev;
  logic [2:0]        st;

  int tests = 0, fails = 0;
  int cyc = 0, end_cyc = 0;
  int wr_ptr = 0, rd_ptr = 0;
  logic [9:0] mem [0:1023];

  typedef struct {
    logic [CH*DW-1:0] rise;
    logic [CH*DW-1:0] fall;
    logic [2*CH-1:0]  ev;
    logic [2:0]       st;
  } exp_t;
  exp_t sb_q[$];
  exp_t e;

  mpt2042_mchnl_dataprc #(
    .CHNL_NUM(CH), .DATA_W(DW), .DELAY_CLKNUM(DLY), .TIMEOUT_CLKNUM(TMO), .CNT_W(16)
  ) dut (
    .i_clk_100m      (clk),
    .i_rst           (rst),
    .i_cdctdc_ready  (cd_rdy),
    .i_tdc_strdy     (strdy),
    .i_laser_sync    (laser),
    .i_chnl_en       (en),
    .i_lvdsfifo_empty(empty),
    .o_lvdsfifo_ren  (ren),
    .i_lvdsfifo_rdata(rdata),
    .o_data_valid    (dvalid),
    .o_rise_data     (rise),
    .o_fall_data     (fall),
    .o_edge_vld      (ev),
    .o_status        (st)
  );

  always #5 clk = ~clk;

  // FIFO model: rdata is valid the clock after ren; end_cyc marks the edge
  // at which a frame-end symbol was placed on rdata.
  assign empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ren && rd_ptr != wr_ptr) begin
      rdata  <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
      if (mem[rd_ptr][9] && mem[rd_ptr] != 10'h29C && mem[rd_ptr] != 10'h3FF)
        end_cyc <= cyc + 1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [9:0] s);
    mem[wr_ptr] = s;
    wr_ptr++;
  endtask

  task automatic push_rec(input logic [1:0] ch, input logic vld, input logic rs,
                          input logic [15:0] t, input int nbytes);
    logic [23:0] r;
    r = {ch, 1'b0, vld, rs, 3'b000, t};
    if (nbytes > 0) push({2'b00, r[23:16]});
    if (nbytes > 1) push({2'b00, r[15:8]});
    if (nbytes > 2) push({2'b00, r[7:0]});
  endtask

  task automatic exp_new(input logic [2:0] s);
    e.rise = '1; e.fall = '1; e.ev = '0; e.st = s;
  endtask

  task automatic exp_edge(input int c, input logic rs, input logic [15:0] t);
    if (rs) begin e.rise[c*DW +: DW] = t; e.ev[c] = 1'b1; end
    else    begin e.fall[c*DW +: DW] = t; e.ev[CH+c] = 1'b1; end
  endtask

  // Returns the laser-sampling edge's cycle number.
  task automatic shot(output int lcyc);
    laser = 1'b1;
    tick();
    lcyc = cyc;
    laser = 1'b0;
  endtask

  task automatic wait_result(input string tag, output int vcyc);
    exp_t x;
    int n;
    n = 0;
    @(negedge clk);
    while (!dvalid && n < 300) begin @(negedge clk); n++; end
    vcyc = cyc;
    if (sb_q.size() > 0) x = sb_q.pop_front();
    else begin x.rise = '0; x.fall = '0; x.ev = '0; x.st = '0; end
    tests++;
    assert (dvalid === 1'b1) else begin
      fails++;
      $error("FAIL %s_strobe got=no o_data_valid within budget exp=strobe", tag);
    end
    if (dvalid === 1'b1) begin
      chk({tag, "_rise"}, rise, x.rise);
      chk({tag, "_fall"}, fall, x.fall);
      chk({tag, "_edge"}, ev, x.ev);
      chk({tag, "_status"}, st, x.st);
      @(negedge clk);
      chk({tag, "_oneshot"}, dvalid, 1'b0);
    end
  endtask

  initial begin
    int lc, vc, c0, seen;
    rst = 1'b1; cd_rdy = 1'b0; strdy = 1'b0; laser = 1'b0; en = '1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_valid", dvalid, 1'b0);
    chk("rst_rise", rise, '0);
    chk("rst_fall", fall, '0);
    chk("rst_edge", ev, '0);
    chk("rst_status", st, '0);
    chk("rst_ren", ren, 1'b0);
    tick();
    rst = 1'b0; cd_rdy = 1'b1;
    repeat (3) tick();

    // 1: basic rise + fall on ch0; frame end -> strobe two clocks later
    exp_new(3'b000); exp_edge(0, 1, 16'h1234); exp_edge(0, 0, 16'h1300);
    sb_q.push_back(e);
    shot(lc);
    push_rec(0, 1, 1, 16'h1234, 3); push(10'h29C);
    push_rec(0, 1, 0, 16'h1300, 3); push(10'h2BC);
    wait_result("t1", vc);
    chk("t1_latency", vc, end_cyc + 2);

    // 2: only the first ch2 rise is kept
    exp_new(3'b000); exp_edge(2, 1, 16'h0100);
    sb_q.push_back(e);
    shot(lc);
    push_rec(2, 1, 1, 16'h0100, 3); push(10'h29C);
    push_rec(2, 1, 1, 16'h0200, 3); push(10'h2BC);
    wait_result("t2", vc);

    // 3: disabled channel and valid=0 record are dropped
    en = 4'b1101;
    exp_new(3'b000);
    sb_q.push_back(e);
    shot(lc);
    push_rec(1, 1, 1, 16'h5555, 3); push(10'h29C);
    push_rec(0, 0, 1, 16'h6666, 3); push(10'h2BC);
    wait_result("t3", vc);
    en = '1;

    // 4: short record discarded by separator; 4th byte ignored
    exp_new(3'b000); exp_edge(3, 0, 16'hABCD);
    sb_q.push_back(e);
    shot(lc);
    push_rec(0, 1, 1, 16'h7777, 2); push(10'h29C);
    push_rec(3, 1, 0, 16'hABCD, 3); push(10'h0FF); push(10'h2BC);
    wait_result("t4", vc);

    // 5a: timeout; OUTPUT is entered TMO clocks after COLLECT entry, which
    // is DLY clocks after the laser edge, strobe one clock after that
    exp_new(3'b001);
    sb_q.push_back(e);
    shot(lc);
    wait_result("t5_tmo", vc);
    chk("t5_tmo_latency", vc, lc + DLY + TMO + 1);

    // 5b: error marker flagged, data still captured
    exp_new(3'b010); exp_edge(1, 0, 16'h4321); exp_edge(1, 1, 16'h0042);
    sb_q.push_back(e);
    shot(lc);
    push_rec(1, 1, 0, 16'h4321, 3); push(10'h3FF); push(10'h29C);
    push_rec(1, 1, 1, 16'h0042, 3); push(10'h2BC);
    wait_result("t5_err", vc);

    // 6: abort mid-COLLECT keeps captures so far
    exp_new(3'b100); exp_edge(0, 1, 16'h0ABC);
    sb_q.push_back(e);
    shot(lc);
    push_rec(0, 1, 1, 16'h0ABC, 3);
    repeat (DLY + 8) tick();
    c0 = cyc;
    strdy = 1'b1; tick(); tick(); strdy = 1'b0;
    wait_result("t6_abort", vc);
    chk("t6_abort_latency", (vc > c0) && (vc - c0 <= 4), 1'b1);

    // strobe in READY is ignored
    strdy = 1'b1; tick(); tick(); strdy = 1'b0;
    repeat (4) tick();
    exp_new(3'b000); exp_edge(1, 1, 16'h00AA);
    sb_q.push_back(e);
    shot(lc);
    push_rec(1, 1, 1, 16'h00AA, 3); push(10'h2BC);
    wait_result("t6_ready_strdy", vc);

    // ready drop mid-frame: frame completes, then IDLE (no reads)
    exp_new(3'b000); exp_edge(3, 1, 16'h3333);
    sb_q.push_back(e);
    shot(lc);
    push_rec(3, 1, 1, 16'h3333, 3);
    repeat (DLY + 6) tick();
    cd_rdy = 1'b0;
    push(10'h2BC);
    wait_result("t7_rdy_drop", vc);
    push(10'h055);
    repeat (5) tick();
    chk("t7_idle_noread", wr_ptr - rd_ptr, 1);
    cd_rdy = 1'b1;
    repeat (4) tick();
    chk("t7_ready_drain", wr_ptr - rd_ptr, 0);

    // reset mid-frame: no strobe, outputs zeroed, back in IDLE
    shot(lc);
    push_rec(2, 1, 1, 16'h0777, 2);
    repeat (DLY + 4) tick();
    cd_rdy = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < DLY + TMO + 10; i++) begin
      @(negedge clk);
      if (dvalid) seen = 1;
    end
    chk("t8_rst_nostrobe", seen, 0);
    chk("t8_rst_rise", rise, '0);
    chk("t8_rst_fall", fall, '0);
    chk("t8_rst_edge", ev, '0);
    chk("t8_rst_status", st, '0);
    tick();
    push(10'h0AA);
    repeat (5) tick();
    chk("t8_idle_noread", wr_ptr - rd_ptr, 1);
    cd_rdy = 1'b1;
    repeat (4) tick();

    // recovery frame after reset
    exp_new(3'b000); exp_edge(2, 0, 16'hBEEF);
    sb_q.push_back(e);
    shot(lc);
    push_rec(2, 1, 0, 16'hBEEF, 3); push(10'h2BC);
    wait_result("t9_recover", vc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
